// File: rtl/ssd1306_spi_driver.sv
// SSD1306 OLED pin driver: panel power sequencing plus 4-wire SPI byte serialiser.
module ssd1306_spi_driver #(
  parameter int unsigned CLK_DIV        = 1,
  parameter int unsigned VDD_DELAY      = 1000,
  parameter int unsigned RST_CYCLES     = 10,
  parameter int unsigned VBAT_OFF_DELAY = 100000,
  parameter int unsigned DLY_W          = 20
) (
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic [7:0] data_in,
  input  logic       dc_in,
  input  logic       valid_in,
  output logic       ready_out,
  input  logic       vbat_en_in,
  input  logic       power_down_in,
  output logic       powered_out,
  output logic       oled_rstn_out,
  output logic       oled_vcdn_out,
  output logic       oled_vbatn_out,
  output logic       oled_csn_out,
  output logic       oled_dc_out,
  output logic       oled_clk_out,
  output logic       oled_mosi_out
);

  // Frame phases: 0 = SETUP, 1..16 = LOW/HIGH per bit (MSB first), 17 = HOLD.
  localparam int unsigned PH_W    = 5;
  localparam logic [PH_W-1:0]  PH_HOLD = PH_W'(17);
  localparam logic [DLY_W-1:0] CNT_ONE = DLY_W'(1);

  typedef enum logic [2:0] {
    PWR_VDD,
    RST_LOW,
    RST_WAIT,
    IDLE,
    BUSY,
    VBAT_OFF,
    OFF
  } state_t;

  state_t           state, state_nx;
  logic [DLY_W-1:0] dly_cnt, cnt_nx;
  logic [PH_W-1:0]  phase, phase_nx;
  logic [7:0]       tx_byte, byte_nx;
  logic             pd_pend, pd_nx;
  logic             dc_nx;
  logic             rstn_nx, vcdn_nx, vbatn_nx, csn_nx, sclk_nx, mosi_nx;
  logic             ready_nx, powered_nx;
  logic [2:0]       bit_idx;

  // State, counters, captured byte and every output pin are registered here.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state          <= PWR_VDD;
      dly_cnt        <= '0;
      phase          <= '0;
      tx_byte        <= '0;
      pd_pend        <= 1'b0;
      oled_rstn_out  <= 1'b0;
      oled_vcdn_out  <= 1'b1;
      oled_vbatn_out <= 1'b1;
      oled_csn_out   <= 1'b1;
      oled_dc_out    <= 1'b0;
      oled_clk_out   <= 1'b1;
      oled_mosi_out  <= 1'b0;
      ready_out      <= 1'b0;
      powered_out    <= 1'b0;
    end else begin
      state          <= state_nx;
      dly_cnt        <= cnt_nx;
      phase          <= phase_nx;
      tx_byte        <= byte_nx;
      pd_pend        <= pd_nx;
      oled_rstn_out  <= rstn_nx;
      oled_vcdn_out  <= vcdn_nx;
      oled_vbatn_out <= vbatn_nx;
      oled_csn_out   <= csn_nx;
      oled_dc_out    <= dc_nx;
      oled_clk_out   <= sclk_nx;
      oled_mosi_out  <= mosi_nx;
      ready_out      <= ready_nx;
      powered_out    <= powered_nx;
    end
  end

  // Next-state logic; dly_cnt counts visible cycles spent in the current wait/phase.
  always_comb begin
    state_nx = state;
    cnt_nx   = dly_cnt + CNT_ONE;
    phase_nx = phase;
    byte_nx  = tx_byte;
    pd_nx    = pd_pend;
    dc_nx    = oled_dc_out;
    case (state)
      PWR_VDD: begin
        if (power_down_in) pd_nx = 1'b1;
        if (dly_cnt >= DLY_W'(VDD_DELAY)) begin
          state_nx = RST_LOW;
          cnt_nx   = CNT_ONE;
        end
      end
      RST_LOW: begin
        if (power_down_in) pd_nx = 1'b1;
        if (dly_cnt >= DLY_W'(RST_CYCLES)) begin
          state_nx = RST_WAIT;
          cnt_nx   = CNT_ONE;
        end
      end
      RST_WAIT: begin
        if (power_down_in) pd_nx = 1'b1;
        if (dly_cnt >= DLY_W'(RST_CYCLES)) begin
          // A request seen during power-up is honoured before any byte can be accepted.
          state_nx = pd_nx ? VBAT_OFF : IDLE;
          cnt_nx   = CNT_ONE;
        end
      end
      IDLE: begin
        cnt_nx = dly_cnt;
        if (power_down_in || pd_pend) begin
          state_nx = VBAT_OFF;
          cnt_nx   = CNT_ONE;
        end else if (valid_in) begin
          state_nx = BUSY;
          cnt_nx   = CNT_ONE;
          phase_nx = '0;
          byte_nx  = data_in;
          dc_nx    = dc_in;
        end
      end
      BUSY: begin
        if (power_down_in) pd_nx = 1'b1;
        if (dly_cnt >= DLY_W'(CLK_DIV)) begin
          cnt_nx = CNT_ONE;
          if (phase == PH_HOLD) begin
            state_nx = pd_nx ? VBAT_OFF : IDLE;
          end else begin
            phase_nx = phase + PH_W'(1);
          end
        end
      end
      VBAT_OFF: begin
        if (dly_cnt >= DLY_W'(VBAT_OFF_DELAY)) begin
          state_nx = OFF;
          cnt_nx   = dly_cnt;
        end
      end
      OFF: begin
        cnt_nx = dly_cnt;
      end
      default: begin
        state_nx = PWR_VDD;
        cnt_nx   = '0;
      end
    endcase
  end

  // Pin values for the upcoming cycle, derived from the next state so outputs stay registered.
  always_comb begin
    rstn_nx    = 1'b1;
    vcdn_nx    = 1'b0;
    vbatn_nx   = 1'b1;
    csn_nx     = 1'b1;
    sclk_nx    = 1'b1;
    mosi_nx    = 1'b0;
    ready_nx   = 1'b0;
    powered_nx = 1'b0;
    bit_idx    = 3'((PH_W'(16) - phase_nx) >> 1);
    case (state_nx)
      RST_LOW: begin
        rstn_nx = 1'b0;
      end
      IDLE: begin
        ready_nx   = 1'b1;
        powered_nx = 1'b1;
        vbatn_nx   = ~vbat_en_in;
      end
      BUSY: begin
        powered_nx = 1'b1;
        vbatn_nx   = ~vbat_en_in;
        csn_nx     = 1'b0;
        if (phase_nx == '0) begin
          mosi_nx = byte_nx[7];
        end else if (phase_nx == PH_HOLD) begin
          mosi_nx = byte_nx[0];
        end else begin
          // Odd phases drive SCLK low with the new bit; even phases raise it for sampling.
          sclk_nx = ~phase_nx[0];
          mosi_nx = byte_nx[bit_idx];
        end
      end
      OFF: begin
        vcdn_nx = 1'b1;
        rstn_nx = 1'b0;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_ssd1306_spi_driver.sv
// Self-checking bench for ssd1306_spi_driver: power sequencing, SPI framing, power-down, reset.
module tb_ssd1306_spi_driver;

  localparam int C     = 2;
  localparam int VDD   = 4;
  localparam int RSTC  = 3;
  localparam int VOFF  = 5;
  localparam int FRAME = 18 * C;

  logic       clk_in = 1'b0;
  logic       reset_in;
  logic [7:0] data_in;
  logic       dc_in;
  logic       valid_in;
  logic       ready_out;
  logic       vbat_en_in;
  logic       power_down_in;
  logic       powered_out;
  logic       oled_rstn_out;
  logic       oled_vcdn_out;
  logic       oled_vbatn_out;
  logic       oled_csn_out;
  logic       oled_dc_out;
  logic       oled_clk_out;
  logic       oled_mosi_out;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic vb_s   = 1'b0;
  logic last_dc;

  ssd1306_spi_driver #(
    .CLK_DIV(C), .VDD_DELAY(VDD), .RST_CYCLES(RSTC), .VBAT_OFF_DELAY(VOFF), .DLY_W(20)
  ) u_dut (
    .clk_in(clk_in), .reset_in(reset_in), .data_in(data_in), .dc_in(dc_in),
    .valid_in(valid_in), .ready_out(ready_out), .vbat_en_in(vbat_en_in),
    .power_down_in(power_down_in), .powered_out(powered_out),
    .oled_rstn_out(oled_rstn_out), .oled_vcdn_out(oled_vcdn_out),
    .oled_vbatn_out(oled_vbatn_out), .oled_csn_out(oled_csn_out),
    .oled_dc_out(oled_dc_out), .oled_clk_out(oled_clk_out),
    .oled_mosi_out(oled_mosi_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock; records vbat_en_in as seen by the edge, samples 1 time unit later.
  task automatic tick();
    vb_s = vbat_en_in;
    @(posedge clk_in);
    #1;
    cyc++;
  endtask

  // Reference SCLK level in frame cycle t (1..18C).
  function automatic logic frame_clk(input int t);
    int ph;
    ph = (t - 1) / C;
    if (ph == 0 || ph >= 17) return 1'b1;
    return logic'((ph - 1) % 2);
  endfunction

  // Reference MOSI in frame cycle t, SETUP and bit phases only.
  function automatic logic frame_mosi(input logic [7:0] b, input int t);
    int ph;
    ph = (t - 1) / C;
    if (ph == 0) return b[7];
    return b[7 - (ph - 1) / 2];
  endfunction

  task automatic check_reset(input string p);
    check_eq({p, "_rstn"},    oled_rstn_out,  0);
    check_eq({p, "_vcdn"},    oled_vcdn_out,  1);
    check_eq({p, "_vbatn"},   oled_vbatn_out, 1);
    check_eq({p, "_csn"},     oled_csn_out,   1);
    check_eq({p, "_dc"},      oled_dc_out,    0);
    check_eq({p, "_clk"},     oled_clk_out,   1);
    check_eq({p, "_mosi"},    oled_mosi_out,  0);
    check_eq({p, "_ready"},   ready_out,      0);
    check_eq({p, "_powered"}, powered_out,    0);
  endtask

  // Called right after reset release with cyc = 0; ends in the first IDLE cycle.
  task automatic power_up();
    int up;
    up = VDD + 2 * RSTC + 1;
    for (int i = 1; i <= up; i++) begin
      vbat_en_in = (i <= 3) ? 1'b1 : 1'($urandom);
      tick();
      check_eq("pu_vcdn", oled_vcdn_out, 0);
      if (cyc > VDD && cyc <= VDD + RSTC) check_eq("pu_rstn_low", oled_rstn_out, 0);
      if (cyc > VDD + RSTC) check_eq("pu_rstn_high", oled_rstn_out, 1);
      check_eq("pu_ready",   ready_out,   32'(cyc >= up));
      check_eq("pu_powered", powered_out, 32'(cyc >= up));
      check_eq("pu_vbatn",   oled_vbatn_out, (cyc >= up) ? 32'(!vb_s) : 32'd1);
      check_eq("pu_csn",     oled_csn_out, 1);
    end
  endtask

  task automatic idle_cycles(input int n, input logic d);
    for (int i = 0; i < n; i++) begin
      valid_in   = 1'b0;
      vbat_en_in = 1'($urandom);
      tick();
      check_eq("idle_ready", ready_out, 1);
      check_eq("idle_csn",   oled_csn_out, 1);
      check_eq("idle_clk",   oled_clk_out, 1);
      check_eq("idle_dc",    oled_dc_out, d);
      check_eq("idle_vbatn", oled_vbatn_out, !vb_s);
    end
  endtask

  // Starts in a cycle with ready_out=1; ends in cycle 18C+1 after acceptance.
  task automatic run_frame(input logic [7:0] b, input logic d, input int pd_t, input bit hold);
    logic [7:0] got_b;
    int   rises;
    logic prev_clk;
    got_b    = '0;
    rises    = 0;
    prev_clk = 1'b1;
    data_in  = b;
    dc_in    = d;
    valid_in = 1'b1;
    for (int t = 1; t <= FRAME; t++) begin
      tick();
      check_eq("fr_csn",     oled_csn_out, 0);
      check_eq("fr_dc",      oled_dc_out, d);
      check_eq("fr_ready",   ready_out, 0);
      check_eq("fr_powered", powered_out, 1);
      check_eq("fr_vbatn",   oled_vbatn_out, !vb_s);
      check_eq("fr_clk",     oled_clk_out, frame_clk(t));
      if (t <= 17 * C) check_eq("fr_mosi", oled_mosi_out, frame_mosi(b, t));
      if (!prev_clk && oled_clk_out) begin
        got_b = {got_b[6:0], oled_mosi_out};
        rises++;
      end
      prev_clk      = oled_clk_out;
      data_in       = 8'($urandom);
      dc_in         = 1'($urandom);
      valid_in      = hold ? 1'b1 : 1'($urandom);
      vbat_en_in    = 1'($urandom);
      power_down_in = (t == pd_t);
    end
    power_down_in = 1'b0;
    valid_in      = hold;
    check_eq("fr_rises", 32'(rises), 8);
    check_eq("fr_byte",  got_b, b);
    tick();
    check_eq("end_csn", oled_csn_out, 1);
    if (pd_t == 0) begin
      check_eq("end_ready",   ready_out, 1);
      check_eq("end_powered", powered_out, 1);
      check_eq("end_dc",      oled_dc_out, d);
      check_eq("end_vbatn",   oled_vbatn_out, !vb_s);
    end else begin
      check_eq("pdb_ready",   ready_out, 0);
      check_eq("pdb_powered", powered_out, 0);
      check_eq("pdb_vbatn",   oled_vbatn_out, 1);
      check_eq("pdb_vcdn",    oled_vcdn_out, 0);
    end
  endtask

  // Called in VBAT_OFF cycle 1; walks the rest of the delay, then checks OFF ignores inputs.
  task automatic power_down_tail();
    for (int j = 2; j <= VOFF; j++) begin
      valid_in   = 1'($urandom);
      vbat_en_in = 1'($urandom);
      tick();
      check_eq("voff_vbatn",   oled_vbatn_out, 1);
      check_eq("voff_powered", powered_out, 0);
      check_eq("voff_ready",   ready_out, 0);
      check_eq("voff_vcdn",    oled_vcdn_out, 0);
    end
    for (int j = 0; j < 20; j++) begin
      valid_in      = 1'b1;
      data_in       = 8'($urandom);
      power_down_in = 1'($urandom);
      vbat_en_in    = 1'($urandom);
      tick();
      check_eq("off_vcdn",  oled_vcdn_out, 1);
      check_eq("off_rstn",  oled_rstn_out, 0);
      check_eq("off_vbatn", oled_vbatn_out, 1);
      check_eq("off_ready", ready_out, 0);
      check_eq("off_csn",   oled_csn_out, 1);
      check_eq("off_clk",   oled_clk_out, 1);
    end
    valid_in      = 1'b0;
    power_down_in = 1'b0;
  endtask

  initial begin
    reset_in      = 1'b1;
    data_in       = '0;
    dc_in         = 1'b0;
    valid_in      = 1'b0;
    vbat_en_in    = 1'b0;
    power_down_in = 1'b0;
    tick();
    tick();
    check_reset("rst");
    reset_in = 1'b0;
    cyc      = 0;
    power_up();

    // VBAT follows the request one cycle later once powered
    vbat_en_in = 1'b0;
    tick();
    check_eq("vbat_off", oled_vbatn_out, 1);
    vbat_en_in = 1'b1;
    tick();
    check_eq("vbat_fall", oled_vbatn_out, 0);

    run_frame(8'hA5, 1'b0, 0, 1'b0);
    idle_cycles(2, 1'b0);
    run_frame(8'hAF, 1'b0, 0, 1'b1);
    run_frame(8'h3C, 1'b1, 0, 1'b0);
    idle_cycles(1, 1'b1);

    for (int k = 0; k < 16; k++) begin
      logic [7:0] b;
      logic       d;
      b = 8'($urandom);
      d = 1'($urandom);
      run_frame(b, d, 0, 1'b0);
      last_dc = d;
      idle_cycles(int'($urandom_range(0, 3)), last_dc);
    end

    // Reset during bit 5 of a frame
    data_in  = 8'h5A;
    dc_in    = 1'b1;
    valid_in = 1'b1;
    for (int t = 1; t <= 5 * C + 1; t++) begin
      tick();
      valid_in = 1'b0;
    end
    check_eq("mid_csn", oled_csn_out, 0);
    check_eq("mid_clk", oled_clk_out, 0);
    #2;
    reset_in = 1'b1;
    #1;
    check_reset("async");
    tick();
    check_reset("hold");
    reset_in = 1'b0;
    cyc      = 0;
    power_up();

    // Power-down in IDLE wins over a simultaneous valid byte
    valid_in      = 1'b1;
    data_in       = 8'hFF;
    power_down_in = 1'b1;
    tick();
    power_down_in = 1'b0;
    check_eq("pdi_ready",   ready_out, 0);
    check_eq("pdi_powered", powered_out, 0);
    check_eq("pdi_csn",     oled_csn_out, 1);
    check_eq("pdi_vbatn",   oled_vbatn_out, 1);
    power_down_tail();

    // Power-down requested during bit 3 of a frame
    reset_in = 1'b1;
    tick();
    reset_in = 1'b0;
    cyc      = 0;
    power_up();
    run_frame(8'hC3, 1'b1, 9 * C + 1, 1'b0);
    power_down_tail();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
